flow_match_engine: RTL and testbench

//  Next-generation multi-thread flow-table lookup engine for the Arya core accelerator slot.
//  - Masked (ternary) IP match against FT_DEPTH entries; lowest matching index wins.
//  - Returns the action, thread tag and hit index in a fixed 2-cycle pipeline.
//  - Keeps per-entry saturating hit counters plus one miss counter, with optional clear-on-read.
//  - Entries are written, masked or invalidated by a config port that stalls lookups.

---
 rtl/flow_pkg.sv | 28 ++
 rtl/ft_sat_counter_bank.sv | 72 +++++++
 rtl/flow_match_engine.sv | 162 ++++++++++++++++
 tb/tb_flow_match_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : flow_pkg                                                     |
// | Description : Shared constants and entry layout for the flow match engine. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package flow_pkg;

    localparam int c_FT_ADDR_WIDTH  = 4;
    localparam int c_FT_DEPTH       = 16;
    localparam int c_NUM_ACTIONS    = 4;
    localparam int c_THREAD_BITS    = 2;
    localparam int c_KEY_WIDTH      = 32;
    localparam int c_CNT_WIDTH      = 32;
    localparam int c_DEFAULT_ACTION = 0;

    // The miss counter sits one past the last entry counter.
    localparam int c_MISS_CNT_ADDR  = c_FT_DEPTH;

    typedef struct packed {
        logic                     valid;
        logic [c_KEY_WIDTH-1:0]   key;
        logic [c_KEY_WIDTH-1:0]   mask;
        logic [c_NUM_ACTIONS-1:0] action;
    } ft_entry_t;

endpackage : flow_pkg
`default_nettype wire

// File: rtl/ft_sat_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ft_sat_counter_bank                                          |
// | Description : Bank of saturating counters with registered clear-on-read.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ft_sat_counter_bank #(
    parameter int NUM_CNT    = 17,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_en,
    input  logic [ADDR_WIDTH-1:0] inc_addr,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_clr,
    output logic                  rd_valid,
    output logic [CNT_WIDTH-1:0]  rd_data
);

    logic [CNT_WIDTH-1:0] r_cnt [NUM_CNT];
    logic [CNT_WIDTH-1:0] w_rd_mux;
    logic                 r_rd_valid;
    logic [CNT_WIDTH-1:0] r_rd_data;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        logic w_inc;
        logic w_clr;

        assign w_inc = inc_en && (inc_addr == ADDR_WIDTH'(i));
        assign w_clr = rd_en && rd_clr && (rd_addr == ADDR_WIDTH'(i));

        // A clear racing an increment leaves the increment counted.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt[i] <= '0;
            end else if (w_clr) begin
                r_cnt[i] <= w_inc ? CNT_WIDTH'(1) : '0;
            end else if (w_inc && !(&r_cnt[i])) begin
                r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                w_rd_mux = r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule : ft_sat_counter_bank
`default_nettype wire

// File: rtl/flow_match_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flow_match_engine                                            |
// | Description : Ternary flow-table lookup, 2-stage pipeline, hit counters.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module flow_match_engine
    import flow_pkg::*;
#(
    parameter int FT_ADDR_WIDTH = c_FT_ADDR_WIDTH,
    parameter int FT_DEPTH      = c_FT_DEPTH,
    parameter int NUM_ACTIONS   = c_NUM_ACTIONS,
    parameter int THREAD_BITS   = c_THREAD_BITS,
    parameter int KEY_WIDTH     = c_KEY_WIDTH,
    parameter int CNT_WIDTH     = c_CNT_WIDTH,
    parameter logic [NUM_ACTIONS-1:0] DEFAULT_ACTION = NUM_ACTIONS'(c_DEFAULT_ACTION)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [KEY_WIDTH-1:0]     req_key,
    input  logic [THREAD_BITS-1:0]   req_thread,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [FT_ADDR_WIDTH-1:0] resp_index,
    output logic [NUM_ACTIONS-1:0]   resp_action,
    output logic [THREAD_BITS-1:0]   resp_thread,
    input  logic                     cfg_we,
    input  logic [FT_ADDR_WIDTH-1:0] cfg_addr,
    input  logic                     cfg_valid,
    input  logic [KEY_WIDTH-1:0]     cfg_key,
    input  logic [KEY_WIDTH-1:0]     cfg_mask,
    input  logic [NUM_ACTIONS-1:0]   cfg_action,
    input  logic                     cnt_rd_en,
    input  logic [FT_ADDR_WIDTH:0]   cnt_rd_addr,
    input  logic                     cnt_clr,
    output logic                     cnt_rd_valid,
    output logic [CNT_WIDTH-1:0]     cnt_rd_data
);

    localparam logic [FT_ADDR_WIDTH:0] c_MISS_ADDR = (FT_ADDR_WIDTH+1)'(FT_DEPTH);

    logic [FT_DEPTH-1:0]    r_valid;
    logic [KEY_WIDTH-1:0]   r_key    [FT_DEPTH];
    logic [KEY_WIDTH-1:0]   r_mask   [FT_DEPTH];
    logic [NUM_ACTIONS-1:0] r_action [FT_DEPTH];

    logic                   w_accept;
    logic [FT_DEPTH-1:0]    w_hit_vec;

    logic                   r_s1_valid;
    logic [THREAD_BITS-1:0] r_s1_thread;
    logic [FT_DEPTH-1:0]    r_s1_hit_vec;

    logic                     w_any;
    logic [FT_ADDR_WIDTH-1:0] w_idx;
    logic [NUM_ACTIONS-1:0]   w_act;

    logic                     r_resp_valid;
    logic                     r_resp_hit;
    logic [FT_ADDR_WIDTH-1:0] r_resp_index;
    logic [NUM_ACTIONS-1:0]   r_resp_action;
    logic [THREAD_BITS-1:0]   r_resp_thread;

    // Config writes own the table for the cycle, so lookups are held off.
    assign w_accept = req_valid && !cfg_we;

    for (genvar i = 0; i < FT_DEPTH; i++) begin : g_entry
        logic w_wr;

        assign w_wr         = cfg_we && (cfg_addr == FT_ADDR_WIDTH'(i));
        assign w_hit_vec[i] = r_valid[i] && (((req_key ^ r_key[i]) & r_mask[i]) == '0);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_valid[i] <= 1'b0;
            end else if (w_wr) begin
                r_valid[i] <= cfg_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (w_wr) begin
                r_key[i]    <= cfg_key;
                r_mask[i]   <= cfg_mask;
                r_action[i] <= cfg_action;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_thread  <= '0;
            r_s1_hit_vec <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_thread  <= req_thread;
                r_s1_hit_vec <= w_hit_vec;
            end
        end
    end

    // Scanning downwards lets the lowest matching index overwrite the others.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_act = DEFAULT_ACTION;
        for (int i = FT_DEPTH - 1; i >= 0; i--) begin
            if (r_s1_hit_vec[i]) begin
                w_any = 1'b1;
                w_idx = FT_ADDR_WIDTH'(i);
                w_act = r_action[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp_valid  <= 1'b0;
            r_resp_hit    <= 1'b0;
            r_resp_index  <= '0;
            r_resp_action <= '0;
            r_resp_thread <= '0;
        end else begin
            r_resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_resp_hit    <= w_any;
                r_resp_index  <= w_idx;
                r_resp_action <= w_act;
                r_resp_thread <= r_s1_thread;
            end
        end
    end

    ft_sat_counter_bank #(
        .NUM_CNT    (FT_DEPTH + 1),
        .ADDR_WIDTH (FT_ADDR_WIDTH + 1),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_cnt_bank (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (r_s1_valid),
        .inc_addr (w_any ? {1'b0, w_idx} : c_MISS_ADDR),
        .rd_en    (cnt_rd_en),
        .rd_addr  (cnt_rd_addr),
        .rd_clr   (cnt_clr),
        .rd_valid (cnt_rd_valid),
        .rd_data  (cnt_rd_data)
    );

    assign req_ready   = !cfg_we;
    assign resp_valid  = r_resp_valid;
    assign resp_hit    = r_resp_hit;
    assign resp_index  = r_resp_index;
    assign resp_action = r_resp_action;
    assign resp_thread = r_resp_thread;

endmodule : flow_match_engine
`default_nettype wire

// File: tb/tb_flow_match_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_flow_match_engine                                         |
// | Description : Scoreboard bench for flow_match_engine (4-bit counters).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_flow_match_engine;

    typedef struct {
        logic       hit;
        logic [3:0] idx;
        logic [3:0] act;
        logic [1:0] thr;
        int         cyc;
    } resp_t;

    typedef struct {
        logic [3:0] val;
        int         cyc;
    } cnt_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_key;
    logic [1:0]  req_thread;
    logic        resp_valid;
    logic        resp_hit;
    logic [3:0]  resp_index;
    logic [3:0]  resp_action;
    logic [1:0]  resp_thread;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic        cfg_valid;
    logic [31:0] cfg_key;
    logic [31:0] cfg_mask;
    logic [3:0]  cfg_action;
    logic        cnt_rd_en;
    logic [4:0]  cnt_rd_addr;
    logic        cnt_clr;
    logic        cnt_rd_valid;
    logic [3:0]  cnt_rd_data;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    resp_t resp_q[$];
    cnt_t  cnt_q[$];
    resp_t mon_r;
    cnt_t  mon_c;

    flow_match_engine #(
        .CNT_WIDTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_key      (req_key),
        .req_thread   (req_thread),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_index   (resp_index),
        .resp_action  (resp_action),
        .resp_thread  (resp_thread),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_valid    (cfg_valid),
        .cfg_key      (cfg_key),
        .cfg_mask     (cfg_mask),
        .cfg_action   (cfg_action),
        .cnt_rd_en    (cnt_rd_en),
        .cnt_rd_addr  (cnt_rd_addr),
        .cnt_clr      (cnt_clr),
        .cnt_rd_valid (cnt_rd_valid),
        .cnt_rd_data  (cnt_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    check_val("unexpected_resp", 1, 0);
                end else begin
                    mon_r = resp_q.pop_front();
                    check_val("resp_hit", resp_hit, mon_r.hit);
                    check_val("resp_index", resp_index, mon_r.idx);
                    check_val("resp_action", resp_action, mon_r.act);
                    check_val("resp_thread", resp_thread, mon_r.thr);
                    check_val("resp_latency", cyc, mon_r.cyc);
                end
            end
            if (cnt_rd_valid) begin
                if (cnt_q.size() == 0) begin
                    check_val("unexpected_cnt", 1, 0);
                end else begin
                    mon_c = cnt_q.pop_front();
                    check_val("cnt_data", cnt_rd_data, mon_c.val);
                    check_val("cnt_latency", cyc, mon_c.cyc);
                end
            end
        end
    end

    task automatic expect_resp(input logic hit, input logic [3:0] idx, input logic [3:0] act,
                               input logic [1:0] thr);
        resp_t e;
        e.hit = hit; e.idx = idx; e.act = act; e.thr = thr; e.cyc = cyc + 2;
        resp_q.push_back(e);
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic v, input logic [31:0] key,
                               input logic [31:0] mask, input logic [3:0] act);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr; cfg_valid = v;
        cfg_key = key; cfg_mask = mask; cfg_action = act;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] key, input logic [1:0] thr, input logic hit,
                         input logic [3:0] idx, input logic [3:0] act);
        @(negedge clk);
        req_valid = 1'b1; req_key = key; req_thread = thr;
        expect_resp(hit, idx, act, thr);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic read_cnt(input logic [4:0] addr, input logic clr, input logic [3:0] exp);
        cnt_t e;
        @(negedge clk);
        cnt_rd_en = 1'b1; cnt_rd_addr = addr; cnt_clr = clr;
        e.val = exp; e.cyc = cyc + 1;
        cnt_q.push_back(e);
        @(negedge clk);
        cnt_rd_en = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (resp_q.size() != 0 || cnt_q.size() != 0); i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        if (resp_q.size() != 0 || cnt_q.size() != 0) begin
            check_val("drain_timeout", resp_q.size() + cnt_q.size(), 0);
            resp_q.delete();
            cnt_q.delete();
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_key = '0; req_thread = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_valid = 1'b0; cfg_key = '0; cfg_mask = '0;
        cfg_action = '0; cnt_rd_en = 1'b0; cnt_rd_addr = '0; cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_resp_valid", resp_valid, 0);
        check_val("rst_cnt_rd_valid", cnt_rd_valid, 0);
        check_val("rst_req_ready", req_ready, 1);
        reset = 1'b1;
        read_cnt(5'd16, 1'b0, 4'd0);
        drain();

        // Exact single-entry hit
        write_entry(4'd3, 1'b1, 32'h0A000001, 32'hFFFFFFFF, 4'h5);
        issue(32'h0A000001, 2'd2, 1'b1, 4'd3, 4'h5);
        idle();
        drain();

        // Priority between a prefix entry and an exact entry
        write_entry(4'd1, 1'b1, 32'hC0A80100, 32'hFFFFFF00, 4'h9);
        write_entry(4'd4, 1'b1, 32'hC0A80107, 32'hFFFFFFFF, 4'hA);
        issue(32'hC0A80107, 2'd1, 1'b1, 4'd1, 4'h9);
        idle();
        write_entry(4'd1, 1'b0, 32'hC0A80100, 32'h00000000, 4'h9);
        issue(32'hC0A80107, 2'd0, 1'b1, 4'd4, 4'hA);
        idle();
        drain();

        // Empty table, back-to-back misses
        write_entry(4'd3, 1'b0, 32'h0, 32'h0, 4'h0);
        write_entry(4'd4, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int t = 0; t < 4; t++) begin
            issue($urandom, 2'(t), 1'b0, 4'd0, 4'h0);
        end
        idle();
        drain();
        read_cnt(5'd16, 1'b0, 4'd4);
        read_cnt(5'd17, 1'b0, 4'd0);
        read_cnt(5'd3, 1'b0, 4'd1);
        read_cnt(5'd1, 1'b0, 4'd1);
        read_cnt(5'd4, 1'b0, 4'd1);
        drain();

        // Saturation, then clear-on-read racing an increment
        write_entry(4'd0, 1'b1, 32'h11111111, 32'hFFFFFFFF, 4'h3);
        for (int n = 0; n < 17; n++) begin
            issue(32'h11111111, 2'(n), 1'b1, 4'd0, 4'h3);
        end
        idle();
        drain();
        read_cnt(5'd0, 1'b0, 4'd15);
        drain();
        issue(32'h11111111, 2'd1, 1'b1, 4'd0, 4'h3);
        begin
            cnt_t e;
            @(negedge clk);
            req_valid = 1'b0;
            cnt_rd_en = 1'b1; cnt_rd_addr = 5'd0; cnt_clr = 1'b1;
            e.val = 4'd15; e.cyc = cyc + 1;
            cnt_q.push_back(e);
            @(negedge clk);
            cnt_rd_en = 1'b0; cnt_clr = 1'b0;
        end
        read_cnt(5'd0, 1'b0, 4'd1);
        drain();

        // Config writes stall a pending request, which then sees the new table
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd5; cfg_valid = 1'b1; cfg_key = 32'h22222222;
        cfg_mask = 32'hFFFFFFFF; cfg_action = 4'h6;
        req_valid = 1'b1; req_key = 32'h22222222; req_thread = 2'd3;
        #1 check_val("ready_cfg0", req_ready, 0);
        @(negedge clk);
        cfg_addr = 4'd6; cfg_key = 32'h33333333; cfg_action = 4'h7;
        #1 check_val("ready_cfg1", req_ready, 0);
        @(negedge clk);
        cfg_addr = 4'd5; cfg_key = 32'h22222222; cfg_action = 4'hC;
        #1 check_val("ready_cfg2", req_ready, 0);
        @(negedge clk);
        cfg_we = 1'b0;
        expect_resp(1'b1, 4'd5, 4'hC, 2'd3);
        #1 check_val("ready_after_cfg", req_ready, 1);
        idle();
        drain();

        // Reset between acceptance and response drops the lookup
        @(negedge clk);
        req_valid = 1'b1; req_key = 32'h11111111; req_thread = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("post_rst_no_resp", resp_valid, 0);
        end
        read_cnt(5'd0, 1'b0, 4'd0);
        read_cnt(5'd16, 1'b0, 4'd0);
        issue(32'h11111111, 2'd2, 1'b0, 4'd0, 4'h0);
        idle();
        drain();

        check_val("queues_empty", resp_q.size() + cnt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "global timeout");
    end

endmodule : tb_flow_match_engine
`default_nettype wire
